regfile_pc_unit: RTL and testbench

Parametrised register file with a program counter for the CPU-register lab datapath. The block holds NREGS general registers of DATA_W bits, with one write port and two registered read ports. It also holds a PC that can increment, decrement, load, or branch-relative, paced by an internal step prescaler. A packed display word (register A readout and PC) feeds the existing seven-segment driver, and data comes from the keypad module.

---
 rtl/regfile_pc_pkg.sv | 14 +
 rtl/regfile_pc_if.sv | 32 +++
 rtl/tick_prescaler.sv | 24 ++
 rtl/regfile_pc_unit.sv | 52 +++++
 tb/tb_regfile_pc_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/regfile_pc_pkg.sv
// regfile_pc_pkg: shared PC mode encoding and address-width helper
//   pc_mode_t : 00 INC, 01 DEC, 10 LOAD, 11 REL
//   addr_w()  : index width for an n-entry register file (at least 1 bit)
package regfile_pc_pkg;
    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_DEC  = 2'b01,
        PC_LOAD = 2'b10,
        PC_REL  = 2'b11
    } pc_mode_t;
    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_pc_if.sv
// regfile_pc_if: bus between the keypad/display side and regfile_pc_unit
//   write port : wr_en, wr_addr, wr_data
//   read ports : rd_addr_a/b in, rd_data_a/b out
//   PC control : pc_mode, pc_hold, pc_data in; pc, tick, disp_word out
interface regfile_pc_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
);
    import regfile_pc_pkg::*;
    localparam int AW = addr_w(NREGS);
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [AW-1:0]       rd_addr_a;
    logic [AW-1:0]       rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    pc_mode_t            pc_mode;
    logic                pc_hold;
    logic [DATA_W-1:0]   pc_data;
    logic [DATA_W-1:0]   pc;
    logic                tick;
    logic [2*DATA_W-1:0] disp_word;
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pc_mode, pc_hold, pc_data,
        input  rd_data_a, rd_data_b, pc, tick, disp_word
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pc_mode, pc_hold, pc_data,
        output rd_data_a, rd_data_b, pc, tick, disp_word
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a registered one-cycle step strobe
//   clk, clr : clock, synchronous active-high reset
//   tick     : high for the cycle after the counter reaches TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] count;
    logic last;
    assign last = count == CW'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= last ? '0 : count + CW'(1);
            tick  <= last;
        end
    end
endmodule

// File: rtl/regfile_pc_unit.sv
// regfile_pc_unit: NREGS x DATA_W register file with two registered read ports and a prescaled PC
//   clk, clr : clock, synchronous active-high reset
//   bus      : write port, read ports A/B, PC control, pc, tick and disp_word = {rd_data_a, pc}
module regfile_pc_unit #(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 4,
    parameter int TICK_DIV = 100000,
    parameter int PC_RESET = 0
) (
    input logic         clk,
    input logic         clr,
    regfile_pc_if.slave bus
);
    import regfile_pc_pkg::*;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] pc, pc_next, pc_step;
    logic [DATA_W-1:0] rd_a, rd_b, rd_next_a, rd_next_b;
    logic wr_ok, tick;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (.clk, .clr, .tick);
    assign wr_ok = bus.wr_en && int'(bus.wr_addr) < NREGS;
    // write-first bypass; a matching valid write implies an in-range read address
    assign rd_next_a = wr_ok && bus.wr_addr == bus.rd_addr_a ? bus.wr_data :
                       int'(bus.rd_addr_a) < NREGS ? regs[bus.rd_addr_a] : '0;
    assign rd_next_b = wr_ok && bus.wr_addr == bus.rd_addr_b ? bus.wr_data :
                       int'(bus.rd_addr_b) < NREGS ? regs[bus.rd_addr_b] : '0;
    // REL: a DATA_W-bit add modulo 2^DATA_W equals adding the sign-extended offset
    always_comb begin
        pc_step = bus.pc_mode == PC_INC ? pc + DATA_W'(1) :
                  bus.pc_mode == PC_DEC ? pc - DATA_W'(1) : pc + bus.pc_data;
        pc_next = bus.pc_hold ? pc :
                  bus.pc_mode == PC_LOAD ? bus.pc_data :
                  tick ? pc_step : pc;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rd_a <= '0;
            rd_b <= '0;
            pc   <= DATA_W'(PC_RESET);
        end else begin
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
            rd_a <= rd_next_a;
            rd_b <= rd_next_b;
            pc   <= pc_next;
        end
    end
    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.pc        = pc;
    assign bus.tick      = tick;
    assign bus.disp_word = {rd_a, pc};
endmodule

// File: tb/tb_regfile_pc_unit.sv
// tb_regfile_pc_unit: directed checks of regfile_pc_unit with two configurations
module tb_regfile_pc_unit;
    import regfile_pc_pkg::*;
    logic clk, clr0, clr1;
    int n_chk = 0;
    int n_fail = 0;

    regfile_pc_if #(.DATA_W(8), .NREGS(4)) bus0 ();
    regfile_pc_if #(.DATA_W(8), .NREGS(3)) bus1 ();

    regfile_pc_unit #(.DATA_W(8), .NREGS(4), .TICK_DIV(4), .PC_RESET(8'h10)) dut0 (
        .clk(clk), .clr(clr0), .bus(bus0.slave)
    );
    regfile_pc_unit #(.DATA_W(8), .NREGS(3), .TICK_DIV(1), .PC_RESET(0)) dut1 (
        .clk(clk), .clr(clr1), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_addr;
        logic [7:0] wr_data;
        logic [1:0] rd_a;
        logic [1:0] rd_b;
        pc_mode_t   mode;
        logic       hold;
        logic [7:0] pd;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_pc;
    } vec_t;
    vec_t vecs [14];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // dut1: TICK_DIV=1, NREGS=3 (address 3 is out of range)
        vecs[0]  = '{1'b1, 2'd0, 8'h11, 2'd0, 2'd1, PC_LOAD, 1'b0, 8'hFE, 8'h11, 8'h00, 8'hFE};
        vecs[1]  = '{1'b1, 2'd1, 8'h22, 2'd0, 2'd1, PC_INC,  1'b0, 8'h00, 8'h11, 8'h22, 8'hFF};
        vecs[2]  = '{1'b1, 2'd3, 8'h33, 2'd3, 2'd2, PC_INC,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, PC_INC,  1'b0, 8'h00, 8'h22, 8'h11, 8'h01};
        vecs[4]  = '{1'b1, 2'd2, 8'h44, 2'd2, 2'd2, PC_LOAD, 1'b0, 8'h01, 8'h44, 8'h44, 8'h01};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd0, PC_DEC,  1'b0, 8'h00, 8'h44, 8'h11, 8'h00};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd1, PC_DEC,  1'b0, 8'h00, 8'h22, 8'h22, 8'hFF};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_LOAD, 1'b0, 8'h05, 8'h11, 8'h44, 8'h05};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_REL,  1'b0, 8'hFD, 8'h11, 8'h44, 8'h02};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_REL,  1'b0, 8'h7F, 8'h11, 8'h44, 8'h81};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_INC,  1'b1, 8'h00, 8'h11, 8'h44, 8'h81};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_LOAD, 1'b1, 8'h3C, 8'h11, 8'h44, 8'h81};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, PC_REL,  1'b0, 8'h80, 8'h11, 8'h44, 8'h01};
        vecs[13] = '{1'b1, 2'd2, 8'h55, 2'd2, 2'd3, PC_LOAD, 1'b0, 8'h3C, 8'h55, 8'h00, 8'h3C};

        clr0 = 1'b1;
        clr1 = 1'b1;
        bus0.wr_en = 1'b1; bus0.wr_addr = 2'd0; bus0.wr_data = 8'hFF;
        bus0.rd_addr_a = 2'd0; bus0.rd_addr_b = 2'd0;
        bus0.pc_mode = PC_LOAD; bus0.pc_hold = 1'b0; bus0.pc_data = 8'h77;
        bus1.wr_en = 1'b0; bus1.wr_addr = 2'd0; bus1.wr_data = 8'h00;
        bus1.rd_addr_a = 2'd0; bus1.rd_addr_b = 2'd0;
        bus1.pc_mode = PC_INC; bus1.pc_hold = 1'b0; bus1.pc_data = 8'h00;
        cyc();
        cyc();
        chk("rst rd_a", bus0.rd_data_a, 8'h00);
        chk("rst rd_b", bus0.rd_data_b, 8'h00);
        chk("rst pc", bus0.pc, 8'h10);
        chk("rst tick", bus0.tick, 1'b0);
        chk("rst disp", bus0.disp_word, 16'h0010);

        // release with PC held in INC; same-cycle write/read bypass of R2
        clr0 = 1'b0;
        bus0.pc_mode = PC_INC; bus0.pc_hold = 1'b1;
        bus0.wr_en = 1'b1; bus0.wr_addr = 2'd2; bus0.wr_data = 8'hA5;
        bus0.rd_addr_a = 2'd2; bus0.rd_addr_b = 2'd0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 1) begin
                chk("bypass rd_a", bus0.rd_data_a, 8'hA5);
                chk("bypass disp", bus0.disp_word, 16'hA510);
                bus0.wr_en = 1'b0;
            end
            chk($sformatf("hold tick c%0d", c), bus0.tick, (c % 4 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("hold pc c%0d", c), bus0.pc, 8'h10);
        end
        bus0.pc_hold = 1'b0;
        cyc();
        chk("release inc pc", bus0.pc, 8'h11);
        chk("release tick", bus0.tick, 1'b0);

        // mode change mid-period: DEC takes effect at the next tick only
        bus0.pc_mode = PC_DEC;
        for (int c = 14; c <= 17; c++) begin
            cyc();
            chk($sformatf("dec pc c%0d", c), bus0.pc, (c == 17) ? 8'h10 : 8'h11);
            chk($sformatf("dec tick c%0d", c), bus0.tick, (c == 16) ? 1'b1 : 1'b0);
        end

        // LOAD without a tick
        bus0.pc_mode = PC_LOAD; bus0.pc_data = 8'h3C; bus0.rd_addr_b = 2'd2;
        cyc();
        chk("load pc", bus0.pc, 8'h3C);
        chk("stored rd_b", bus0.rd_data_b, 8'hA5);

        // clr together with a write and a LOAD
        clr0 = 1'b1;
        bus0.wr_en = 1'b1; bus0.wr_addr = 2'd1; bus0.wr_data = 8'h99; bus0.pc_data = 8'h77;
        cyc();
        chk("clr pc", bus0.pc, 8'h10);
        chk("clr rd_a", bus0.rd_data_a, 8'h00);
        chk("clr rd_b", bus0.rd_data_b, 8'h00);
        chk("clr tick", bus0.tick, 1'b0);
        clr0 = 1'b0;
        bus0.wr_en = 1'b0; bus0.rd_addr_a = 2'd1; bus0.rd_addr_b = 2'd2; bus0.pc_mode = PC_INC;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) begin
                chk("cleared R1", bus0.rd_data_a, 8'h00);
                chk("cleared R2", bus0.rd_data_b, 8'h00);
            end
            chk($sformatf("restart tick c%0d", c), bus0.tick, (c == 4) ? 1'b1 : 1'b0);
            chk($sformatf("restart pc c%0d", c), bus0.pc, (c == 5) ? 8'h11 : 8'h10);
        end

        // dut1 table: TICK_DIV=1 steps on every cycle after the first
        chk("rst1 pc", bus1.pc, 8'h00);
        chk("rst1 tick", bus1.tick, 1'b0);
        clr1 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus1.wr_en = vecs[i].wr_en; bus1.wr_addr = vecs[i].wr_addr; bus1.wr_data = vecs[i].wr_data;
            bus1.rd_addr_a = vecs[i].rd_a; bus1.rd_addr_b = vecs[i].rd_b;
            bus1.pc_mode = vecs[i].mode; bus1.pc_hold = vecs[i].hold; bus1.pc_data = vecs[i].pd;
            cyc();
            chk($sformatf("v%0d rd_a", i), bus1.rd_data_a, vecs[i].exp_a);
            chk($sformatf("v%0d rd_b", i), bus1.rd_data_b, vecs[i].exp_b);
            chk($sformatf("v%0d pc", i), bus1.pc, vecs[i].exp_pc);
            chk($sformatf("v%0d disp", i), bus1.disp_word, {vecs[i].exp_a, vecs[i].exp_pc});
            chk($sformatf("v%0d tick", i), bus1.tick, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
